pll_reset_sequencer: RTL and testbench

- Consumes the `locked` status of the fabric PLL wrapper and drives that wrapper's `rst` input.
- Produces a clean system reset for downstream logic. It deasserts only after the PLL has held lock for a programmable time.
- Runs on `refclk`, the 50 MHz board clock that feeds the PLL, so it keeps operating while the PLL output is dead.
- On lock loss it re-resets the PLL automatically and counts the events for debug.

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 113 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 50000;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned CNT_W_DEF               = 16;
  localparam int unsigned EVT_W_DEF               = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with async active-high reset to a chosen value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset and system reset from the refclk domain, re-resetting the
// PLL on lock loss or lock-wait timeout and counting those events.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W               = CNT_W_DEF,
  parameter int unsigned EVT_W               = EVT_W_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             lock_lost_clr,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             lock_lost,
  output logic [EVT_W-1:0] relock_count,
  output logic [EVT_W-1:0] timeout_count
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX      = '1;

  pll_seq_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             locked_s;
  logic             timeout_evt, relock_evt;
  logic             pll_rst_nxt, sys_rst_nxt, lock_lost_nxt;
  logic [EVT_W-1:0] relock_count_nxt, timeout_count_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      lock_lost     <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pll_rst       <= pll_rst_nxt;
      sys_rst       <= sys_rst_nxt;
      lock_lost     <= lock_lost_nxt;
      relock_count  <= relock_count_nxt;
      timeout_count <= timeout_count_nxt;
    end
  end

  // Next state, counter and registered-output next values; outputs follow state_nxt.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    timeout_evt = 1'b0;
    relock_evt  = 1'b0;

    unique case (state)
      PLL_RST: begin
        if (cnt == PLL_RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s)                state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt  = PLL_RST;
          relock_evt = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    pll_rst_nxt = (state_nxt == PLL_RST);
    sys_rst_nxt = (state_nxt != RUN);

    // A lock-loss event takes priority over a coincident clear.
    lock_lost_nxt = lock_lost;
    if (relock_evt)         lock_lost_nxt = 1'b1;
    else if (lock_lost_clr) lock_lost_nxt = 1'b0;

    relock_count_nxt  = relock_count;
    timeout_count_nxt = timeout_count;
    if (relock_evt && (relock_count != EVT_MAX))
      relock_count_nxt = relock_count + EVT_W'(1);
    if (timeout_evt && (timeout_count != EVT_MAX))
      timeout_count_nxt = timeout_count + EVT_W'(1);
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned EVT_W = 2;

  logic             refclk;
  logic             rst;
  logic             locked;
  logic             lock_lost_clr;
  logic             pll_rst;
  logic             sys_rst;
  logic             lock_lost;
  logic [EVT_W-1:0] relock_count;
  logic [EVT_W-1:0] timeout_count;

  int tests;
  int fails;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .CNT_W               (16),
    .EVT_W               (EVT_W)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .lock_lost_clr (lock_lost_clr),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .lock_lost     (lock_lost),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Bounded wait for sys_rst to deassert, then check it did.
  task automatic wait_run(input string tag);
    for (int i = 0; i < 200 && sys_rst; i++) tick(1);
    check(tag, 32'(sys_rst), 32'd0);
  endtask

  // Drop lock while in RUN; the loss edge is the third edge after the drop.
  task automatic lose_lock(input logic clr_on_loss);
    locked = 1'b0;
    tick(2);
    lock_lost_clr = clr_on_loss;
    tick(1);
    lock_lost_clr = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    locked = 1'b0;
    lock_lost_clr = 1'b0;

    // Reset values without any clock edge.
    #2;
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_relock", 32'(relock_count), 32'd0);
    check("rst_timeout", 32'(timeout_count), 32'd0);
    tick(2);
    rst = 1'b0;

    // No lock: 4 high, 20 low, 4 high, 20 low, high again.
    tick(3);  check("t1_prst_e3", 32'(pll_rst), 32'd1);
    tick(1);  check("t1_prst_e4", 32'(pll_rst), 32'd0);
    tick(19); check("t1_prst_e23", 32'(pll_rst), 32'd0);
              check("t1_to_e23", 32'(timeout_count), 32'd0);
    tick(1);  check("t1_prst_e24", 32'(pll_rst), 32'd1);
              check("t1_to_e24", 32'(timeout_count), 32'd1);
    tick(3);  check("t1_prst_e27", 32'(pll_rst), 32'd1);
    tick(1);  check("t1_prst_e28", 32'(pll_rst), 32'd0);
    tick(19); check("t1_prst_e47", 32'(pll_rst), 32'd0);
    tick(1);  check("t1_prst_e48", 32'(pll_rst), 32'd1);
              check("t1_to_e48", 32'(timeout_count), 32'd2);
              check("t1_sys_rst", 32'(sys_rst), 32'd1);

    // Lock 10 cycles after pll_rst falls; first capture edge is e15, RUN at e25.
    reset_pulse();
    tick(4);  check("t2_prst_fall", 32'(pll_rst), 32'd0);
    tick(10);
    locked = 1'b1;
    tick(10); check("t2_sys_e24", 32'(sys_rst), 32'd1);
    tick(1);  check("t2_sys_e25", 32'(sys_rst), 32'd0);
              check("t2_prst", 32'(pll_rst), 32'd0);
              check("t2_timeout", 32'(timeout_count), 32'd0);

    // Glitch in STABLE: high 5, low 3; stable count restarts, RUN at e23.
    reset_pulse();
    tick(4);
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(3);  check("t3_sys_e12", 32'(sys_rst), 32'd1);
    locked = 1'b1;
    tick(3);  check("t3_sys_e15", 32'(sys_rst), 32'd1);
    tick(7);  check("t3_sys_e22", 32'(sys_rst), 32'd1);
              check("t3_prst_e22", 32'(pll_rst), 32'd0);
    tick(1);  check("t3_sys_e23", 32'(sys_rst), 32'd0);

    // Lock loss in RUN: reaction on the third edge.
    tick(2);
    locked = 1'b0;
    tick(2);  check("t4_prst_e2", 32'(pll_rst), 32'd0);
              check("t4_sys_e2", 32'(sys_rst), 32'd0);
    tick(1);  check("t4_prst_e3", 32'(pll_rst), 32'd1);
              check("t4_sys_e3", 32'(sys_rst), 32'd1);
              check("t4_lost", 32'(lock_lost), 32'd1);
              check("t4_relock", 32'(relock_count), 32'd1);
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
              check("t4_clr_lost", 32'(lock_lost), 32'd0);
              check("t4_clr_relock", 32'(relock_count), 32'd1);

    // Three more losses: saturate at 3, clear loses to a coincident loss.
    locked = 1'b1;
    wait_run("t5_run2");
    lose_lock(1'b0);
    check("t5_relock2", 32'(relock_count), 32'd2);
    locked = 1'b1;
    wait_run("t5_run3");
    lose_lock(1'b0);
    check("t5_relock3", 32'(relock_count), 32'd3);
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    check("t5_clr3", 32'(lock_lost), 32'd0);
    locked = 1'b1;
    wait_run("t5_run4");
    lose_lock(1'b1);
    check("t5_relock_sat", 32'(relock_count), 32'd3);
    check("t5_set_wins", 32'(lock_lost), 32'd1);
    check("t5_prst4", 32'(pll_rst), 32'd1);

    // Async reset between edges while in WAIT_LOCK.
    tick(6);
    check("t6_prst_wait", 32'(pll_rst), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_prst", 32'(pll_rst), 32'd1);
    check("t6_async_sys", 32'(sys_rst), 32'd1);
    check("t6_async_lost", 32'(lock_lost), 32'd0);
    check("t6_async_relock", 32'(relock_count), 32'd0);
    check("t6_async_to", 32'(timeout_count), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);  check("t6_prst_e3", 32'(pll_rst), 32'd1);
    tick(1);  check("t6_prst_e4", 32'(pll_rst), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
